// File: rtl/conv_pkg.sv
// Shared types and helpers for the convolution operand sequencer.
package conv_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    STREAM,
    FLUSH,
    DRAIN,
    DONE
  } state_t;

  localparam int unsigned OPW  = 9;   // MAC operand width (pixel / weight)
  localparam int unsigned RESW = 21;  // MAC saturated result width
  localparam int unsigned CNTW = 10;  // MAC beat counter width

  // Number of valid window rows for a given image/kernel height.
  function automatic int unsigned calc_oh(input int unsigned img_h, input int unsigned k_h);
    return img_h - k_h + 1;
  endfunction

  // Number of valid window columns for a given image/kernel width.
  function automatic int unsigned calc_ow(input int unsigned img_w, input int unsigned k_w);
    return img_w - k_w + 1;
  endfunction

endpackage

// File: rtl/conv_addr_gen.sv
// Window walker: oy/ox/ky/kx counters (kx fastest) and image/kernel read addresses.
module conv_addr_gen
  import conv_pkg::*;
#(
  parameter int unsigned IMG_H = 28,
  parameter int unsigned IMG_W = 28,
  parameter int unsigned K_H   = 3,
  parameter int unsigned K_W   = 3,
  parameter int unsigned AW    = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          step,
  output logic [AW-1:0] img_addr,
  output logic [AW-1:0] ker_addr,
  output logic          last
);

  localparam int unsigned OH = calc_oh(IMG_H, K_H);
  localparam int unsigned OW = calc_ow(IMG_W, K_W);
  localparam logic [AW-1:0] OY_MAX = AW'(OH - 1);
  localparam logic [AW-1:0] OX_MAX = AW'(OW - 1);
  localparam logic [AW-1:0] KY_MAX = AW'(K_H - 1);
  localparam logic [AW-1:0] KX_MAX = AW'(K_W - 1);

  logic [AW-1:0] oy, ox, ky, kx;
  logic          kx_wrap, ky_wrap, ox_wrap, oy_wrap;

  assign kx_wrap = (kx == KX_MAX);
  assign ky_wrap = (ky == KY_MAX);
  assign ox_wrap = (ox == OX_MAX);
  assign oy_wrap = (oy == OY_MAX);
  assign last    = kx_wrap & ky_wrap & ox_wrap & oy_wrap;

  assign img_addr = (oy + ky) * AW'(IMG_W) + (ox + kx);
  assign ker_addr = ky * AW'(K_W) + kx;

  // Nested counters advance one kernel tap per step, wrapping back to 0 after the last tap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      {oy, ox, ky, kx} <= '0;
    end else if (clear) begin
      {oy, ox, ky, kx} <= '0;
    end else if (step) begin
      kx <= kx_wrap ? '0 : kx + AW'(1);
      if (kx_wrap) begin
        ky <= ky_wrap ? '0 : ky + AW'(1);
        if (ky_wrap) begin
          ox <= ox_wrap ? '0 : ox + AW'(1);
          if (ox_wrap) oy <= oy_wrap ? '0 : oy + AW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/conv_operand_sequencer.sv
// Convolution operand sequencer: streams pixel/weight pairs to the MAC for every valid
// KxK window and writes each window result to the result RAM.
// Optional macro RELU_EN: clamp negative results to 0 before writing.
module conv_operand_sequencer
  import conv_pkg::*;
#(
  parameter int unsigned IMG_H = 28,
  parameter int unsigned IMG_W = 28,
  parameter int unsigned K_H   = 3,
  parameter int unsigned K_W   = 3,
  parameter int unsigned AW    = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  output logic                   busy,
  output logic                   frame_done,
  output logic [AW-1:0]          img_addr,
  input  logic signed [OPW-1:0]  img_data,
  output logic [AW-1:0]          ker_addr,
  input  logic signed [OPW-1:0]  ker_data,
  output logic signed [OPW-1:0]  mac_in1,
  output logic signed [OPW-1:0]  mac_in2,
  output logic [OPW-1:0]         mac_ht,
  output logic [OPW-1:0]         mac_wt,
  output logic                   mac_clear,
  output logic                   mac_enable,
  input  logic signed [RESW-1:0] mac_out,
  input  logic                   mac_done,
  output logic [AW-1:0]          res_addr,
  output logic signed [RESW-1:0] res_data,
  output logic                   res_we
);

  localparam int unsigned OH = calc_oh(IMG_H, K_H);
  localparam int unsigned OW = calc_ow(IMG_W, K_W);
  localparam logic [AW-1:0] LAST_IDX = AW'(OH * OW - 1);

  state_t                 state, state_nxt;
  logic                   valid;       // RAM data for an issued beat is on img_data/ker_data
  logic                   flush_beat;  // trailing zero-operand beat
  logic                   en_q;        // mac_enable of the previous cycle
  logic                   capture;
  logic                   gen_clear, gen_step, addr_last;
  logic [AW-1:0]          res_idx;
  logic signed [RESW-1:0] res_val;

  conv_addr_gen #(
    .IMG_H (IMG_H),
    .IMG_W (IMG_W),
    .K_H   (K_H),
    .K_W   (K_W),
    .AW    (AW)
  ) u_addr_gen (
    .clk      (clk),
    .reset    (reset),
    .clear    (gen_clear),
    .step     (gen_step),
    .img_addr (img_addr),
    .ker_addr (ker_addr),
    .last     (addr_last)
  );

  assign mac_ht = OPW'(K_H);
  assign mac_wt = OPW'(K_W);

  // The last data beat lands in the FLUSH cycle because of the RAM latency, so the
  // zero-operand beat is carried by a register one cycle later (first DRAIN cycle).
  assign mac_enable = valid | flush_beat;
  assign mac_in1    = valid ? img_data : '0;
  assign mac_in2    = valid ? ker_data : '0;

`ifdef RELU_EN
  assign res_val = mac_out[RESW-1] ? '0 : mac_out;
`else
  assign res_val = mac_out;
`endif

  assign res_we   = capture;
  assign res_addr = capture ? res_idx : '0;
  assign res_data = capture ? res_val : '0;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Beat pipeline flags and result index.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid      <= 1'b0;
      flush_beat <= 1'b0;
      en_q       <= 1'b0;
      res_idx    <= '0;
    end else begin
      valid      <= (state == STREAM);
      flush_beat <= (state == FLUSH);
      en_q       <= mac_enable;
      if (state == CLEAR)  res_idx <= '0;
      else if (capture)    res_idx <= res_idx + AW'(1);
    end
  end

  // Next-state logic and state-decoded controls.
  always_comb begin
    state_nxt  = state;
    busy       = 1'b0;
    frame_done = 1'b0;
    mac_clear  = 1'b0;
    gen_clear  = 1'b0;
    gen_step   = 1'b0;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = CLEAR;
      end
      CLEAR: begin
        busy      = 1'b1;
        mac_clear = 1'b1;
        gen_clear = 1'b1;
        state_nxt = STREAM;
      end
      STREAM: begin
        busy     = 1'b1;
        gen_step = 1'b1;
        capture  = mac_done & en_q;
        if (addr_last) state_nxt = FLUSH;
      end
      FLUSH: begin
        busy      = 1'b1;
        capture   = mac_done & en_q;
        state_nxt = DRAIN;
      end
      DRAIN: begin
        busy    = 1'b1;
        capture = mac_done & en_q;
        if (capture && res_idx == LAST_IDX) state_nxt = DONE;
      end
      DONE: begin
        frame_done = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_conv_operand_sequencer.sv
// Directed bench for conv_operand_sequencer with behavioural RAMs and MAC.
// Instance A: 4x4 image, 3x3 kernel. Instance B: 5x5 image, 5x5 kernel.
module tb_conv_operand_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // ---------------- instance A ----------------
  logic               start_a = 1'b0, busy_a, fd_a, clr_a, en_a, done_a = 1'b0, we_a;
  logic [9:0]         img_addr_a, ker_addr_a, res_addr_a;
  logic signed [8:0]  img_data_a = '0, ker_data_a = '0, in1_a, in2_a;
  logic [8:0]         ht_a, wt_a;
  logic signed [20:0] out_a = '0, res_data_a;
  logic signed [8:0]  img_a [0:15];
  logic signed [8:0]  ker_a [0:15];
  int                 acc_a = 0, cnt_a = 0;

  conv_operand_sequencer #(.IMG_H(4), .IMG_W(4), .K_H(3), .K_W(3), .AW(10)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .busy(busy_a), .frame_done(fd_a),
    .img_addr(img_addr_a), .img_data(img_data_a), .ker_addr(ker_addr_a), .ker_data(ker_data_a),
    .mac_in1(in1_a), .mac_in2(in2_a), .mac_ht(ht_a), .mac_wt(wt_a), .mac_clear(clr_a),
    .mac_enable(en_a), .mac_out(out_a), .mac_done(done_a),
    .res_addr(res_addr_a), .res_data(res_data_a), .res_we(we_a)
  );

  // ---------------- instance B ----------------
  logic               start_b = 1'b0, busy_b, fd_b, clr_b, en_b, done_b = 1'b0, we_b;
  logic [9:0]         img_addr_b, ker_addr_b, res_addr_b;
  logic signed [8:0]  img_data_b = '0, ker_data_b = '0, in1_b, in2_b;
  logic [8:0]         ht_b, wt_b;
  logic signed [20:0] out_b = '0, res_data_b;
  logic signed [8:0]  img_b [0:31];
  logic signed [8:0]  ker_b [0:31];
  int                 acc_b = 0, cnt_b = 0;

  conv_operand_sequencer #(.IMG_H(5), .IMG_W(5), .K_H(5), .K_W(5), .AW(10)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .busy(busy_b), .frame_done(fd_b),
    .img_addr(img_addr_b), .img_data(img_data_b), .ker_addr(ker_addr_b), .ker_data(ker_data_b),
    .mac_in1(in1_b), .mac_in2(in2_b), .mac_ht(ht_b), .mac_wt(wt_b), .mac_clear(clr_b),
    .mac_enable(en_b), .mac_out(out_b), .mac_done(done_b),
    .res_addr(res_addr_b), .res_data(res_data_b), .res_we(we_b)
  );

  function automatic logic signed [20:0] sat21(input int v);
    if (v > 1048575)  return 21'sd1048575;
    if (v < -1048576) return -21'sd1048576;
    return v[20:0];
  endfunction

  // Synchronous RAMs: data valid the cycle after the address.
  always @(posedge clk) begin
    img_data_a <= img_a[img_addr_a[3:0]];
    ker_data_a <= ker_a[ker_addr_a[3:0]];
    img_data_b <= img_b[img_addr_b[4:0]];
    ker_data_b <= ker_b[ker_addr_b[4:0]];
  end

  // MAC model A (N=9): beat N+1 emits the saturated sum and starts the next window.
  always @(posedge clk) begin
    if (clr_a) begin
      acc_a <= 0; cnt_a <= 0; done_a <= 1'b0; out_a <= '0;
    end else if (en_a) begin
      if (cnt_a == 9) begin
        out_a <= sat21(acc_a); done_a <= 1'b1; acc_a <= int'(in1_a) * int'(in2_a); cnt_a <= 1;
      end else begin
        acc_a <= acc_a + int'(in1_a) * int'(in2_a); cnt_a <= cnt_a + 1; done_a <= 1'b0;
      end
    end
  end

  // MAC model B (N=25).
  always @(posedge clk) begin
    if (clr_b) begin
      acc_b <= 0; cnt_b <= 0; done_b <= 1'b0; out_b <= '0;
    end else if (en_b) begin
      if (cnt_b == 25) begin
        out_b <= sat21(acc_b); done_b <= 1'b1; acc_b <= int'(in1_b) * int'(in2_b); cnt_b <= 1;
      end else begin
        acc_b <= acc_b + int'(in1_b) * int'(in2_b); cnt_b <= cnt_b + 1; done_b <= 1'b0;
      end
    end
  end

  // Frame observation results.
  int                 wr_n, fd_n, en_n, clr_n, fd_gap;
  logic               busy_after;
  logic [9:0]         wr_addr [0:7];
  logic signed [20:0] wr_data [0:7];

  // Runs one frame on instance A (inst=0) or B (inst=1), bounded to 300 cycles.
  task automatic run_frame(input bit inst, input int restart_at, input bit poke_done);
    int fd_cyc, last_wr;
    logic we, fd, en, clr;
    wr_n = 0; fd_n = 0; en_n = 0; clr_n = 0; fd_gap = -1; fd_cyc = -1; last_wr = -1;
    for (int i = 0; i < 8; i++) begin wr_addr[i] = 'x; wr_data[i] = 'x; end
    @(negedge clk);
    if (inst) start_b = 1'b1; else start_a = 1'b1;
    for (int cyc = 1; cyc < 300; cyc++) begin
      @(negedge clk);
      start_a = 1'b0; start_b = 1'b0;
      we  = inst ? we_b  : we_a;
      fd  = inst ? fd_b  : fd_a;
      en  = inst ? en_b  : en_a;
      clr = inst ? clr_b : clr_a;
      if (we) begin
        if (wr_n < 8) begin
          wr_addr[wr_n] = inst ? res_addr_b : res_addr_a;
          wr_data[wr_n] = inst ? res_data_b : res_data_a;
        end
        wr_n++; last_wr = cyc;
      end
      if (en)  en_n++;
      if (clr) clr_n++;
      if (fd) begin
        fd_n++;
        if (fd_n == 1) begin fd_cyc = cyc; fd_gap = cyc - last_wr; end
      end
      if (cyc == restart_at || (poke_done && fd)) begin
        if (inst) start_b = 1'b1; else start_a = 1'b1;
      end
      if (fd_cyc > 0 && cyc >= fd_cyc + 6) break;
    end
    start_a = 1'b0; start_b = 1'b0;
    busy_after = inst ? busy_b : busy_a;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy_a); end
    checks++; if (fd_a !== 1'b0) begin errors++; $display("FAIL reset_frame_done got=%b want=0", fd_a); end
    checks++; if (we_a !== 1'b0 || en_a !== 1'b0 || clr_a !== 1'b0) begin errors++;
      $display("FAIL reset_strobes got we=%b en=%b clr=%b want 0", we_a, en_a, clr_a); end
    checks++; if (img_addr_a !== 10'd0 || ker_addr_a !== 10'd0 || res_addr_a !== 10'd0) begin errors++;
      $display("FAIL reset_addrs got img=%0d ker=%0d res=%0d want 0", img_addr_a, ker_addr_a, res_addr_a); end
    checks++; if (in1_a !== 9'sd0 || in2_a !== 9'sd0 || res_data_a !== 21'sd0) begin errors++;
      $display("FAIL reset_data got in1=%0d in2=%0d res=%0d want 0", in1_a, in2_a, res_data_a); end
    checks++; if (ht_a !== 9'd3 || wt_a !== 9'd3) begin errors++;
      $display("FAIL reset_ht_wt got ht=%0d wt=%0d want 3/3", ht_a, wt_a); end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic fill_a(input int mode);
    // mode 0: image 1, kernel 1; 1: image ramp, kernel centre 1; 2: image 1, kernel -1
    for (int i = 0; i < 16; i++) begin
      img_a[i] = (mode == 1) ? 9'(i) : 9'sd1;
      ker_a[i] = (mode == 0) ? 9'sd1 : (mode == 2) ? -9'sd1 : ((i == 4) ? 9'sd1 : 9'sd0);
    end
  endtask

  task automatic test_all_ones();
    fill_a(0);
    run_frame(1'b0, 0, 1'b0);
    checks++; if (wr_n !== 4) begin errors++; $display("FAIL ones_writes got=%0d want=4", wr_n); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (wr_addr[i] !== 10'(i) || wr_data[i] !== 21'sd9) begin errors++;
        $display("FAIL ones_w%0d got addr=%0d data=%0d want addr=%0d data=9", i, wr_addr[i], wr_data[i], i); end
    end
    checks++; if (fd_n !== 1 || fd_gap !== 1) begin errors++;
      $display("FAIL ones_frame_done got count=%0d gap=%0d want 1/1", fd_n, fd_gap); end
    checks++; if (en_n !== 37 || clr_n !== 1) begin errors++;
      $display("FAIL ones_beats got en=%0d clr=%0d want 37/1", en_n, clr_n); end
    checks++; if (busy_after !== 1'b0) begin errors++; $display("FAIL ones_busy_after got=%b want=0", busy_after); end
  endtask

  task automatic test_ramp_identity();
    logic signed [20:0] exp_d [0:3];
    exp_d[0] = 21'sd5; exp_d[1] = 21'sd6; exp_d[2] = 21'sd9; exp_d[3] = 21'sd10;
    fill_a(1);
    run_frame(1'b0, 0, 1'b0);
    checks++; if (wr_n !== 4) begin errors++; $display("FAIL ramp_writes got=%0d want=4", wr_n); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (wr_addr[i] !== 10'(i) || wr_data[i] !== exp_d[i]) begin errors++;
        $display("FAIL ramp_w%0d got addr=%0d data=%0d want addr=%0d data=%0d", i, wr_addr[i], wr_data[i], i, exp_d[i]); end
    end
  endtask

  task automatic test_negative_kernel();
`ifdef RELU_EN
    logic signed [20:0] exp_v = 21'sd0;
`else
    logic signed [20:0] exp_v = -21'sd9;
`endif
    fill_a(2);
    run_frame(1'b0, 0, 1'b0);
    checks++; if (wr_n !== 4) begin errors++; $display("FAIL neg_writes got=%0d want=4", wr_n); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (wr_data[i] !== exp_v) begin errors++;
        $display("FAIL neg_w%0d got=%0d want=%0d", i, wr_data[i], exp_v); end
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 32; i++) begin img_b[i] = -9'sd256; ker_b[i] = -9'sd256; end
    run_frame(1'b1, 0, 1'b0);
    checks++; if (wr_n !== 1) begin errors++; $display("FAIL sat_writes got=%0d want=1", wr_n); end
    checks++; if (wr_addr[0] !== 10'd0 || wr_data[0] !== 21'sd1048575) begin errors++;
      $display("FAIL sat_value got addr=%0d data=%0d want addr=0 data=1048575", wr_addr[0], wr_data[0]); end
    checks++; if (ht_b !== 9'd5 || wt_b !== 9'd5 || fd_n !== 1 || en_n !== 26) begin errors++;
      $display("FAIL sat_misc got ht=%0d wt=%0d fd=%0d en=%0d want 5/5/1/26", ht_b, wt_b, fd_n, en_n); end
  endtask

  task automatic test_reset_mid_stream();
    fill_a(0);
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    repeat (9) @(negedge clk);
    checks++; if (busy_a !== 1'b1 || en_a !== 1'b1) begin errors++;
      $display("FAIL midrst_streaming got busy=%b en=%b want 1/1", busy_a, en_a); end
    reset = 1'b0;
    @(negedge clk);
    checks++; if (busy_a !== 1'b0 || we_a !== 1'b0 || en_a !== 1'b0) begin errors++;
      $display("FAIL midrst_idle got busy=%b we=%b en=%b want 0", busy_a, we_a, en_a); end
    reset = 1'b1;
    @(negedge clk);
    run_frame(1'b0, 0, 1'b0);
    checks++; if (wr_n !== 4 || fd_n !== 1) begin errors++;
      $display("FAIL midrst_rerun got writes=%0d fd=%0d want 4/1", wr_n, fd_n); end
    checks++; if (wr_addr[0] !== 10'd0 || wr_data[0] !== 21'sd9 || wr_addr[3] !== 10'd3) begin errors++;
      $display("FAIL midrst_index got a0=%0d d0=%0d a3=%0d want 0/9/3", wr_addr[0], wr_data[0], wr_addr[3]); end
  endtask

  task automatic test_start_while_busy();
    fill_a(0);
    run_frame(1'b0, 10, 1'b1);
    checks++; if (wr_n !== 4) begin errors++; $display("FAIL busystart_writes got=%0d want=4", wr_n); end
    checks++; if (fd_n !== 1 || clr_n !== 1) begin errors++;
      $display("FAIL busystart_frames got fd=%0d clr=%0d want 1/1", fd_n, clr_n); end
    checks++; if (busy_after !== 1'b0 || en_n !== 37) begin errors++;
      $display("FAIL busystart_idle got busy=%b en=%0d want 0/37", busy_after, en_n); end
  endtask

  initial begin
    test_reset();
    test_all_ones();
    test_ramp_identity();
    test_negative_kernel();
    test_saturation();
    test_reset_mid_stream();
    test_start_while_busy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

endmodule
